// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: branch funct3 codes, buffer states, XLEN.
// Used by branch_resolve_stage and its branch_cond sub-module.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/branch_resolve_stage_if.sv
// Handshake bundle between the ALU, branch_resolve_stage and writeback/fetch.
// master drives the upstream entry and out_ready; slave is the stage itself.
interface branch_resolve_stage_if #(
    parameter int N = riscv_pkg::XLEN
);
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] alu_result;
    logic         flag_v;
    logic         flag_c;
    logic         flag_n;
    logic         flag_z;
    logic         is_branch;
    logic [2:0]   funct3;
    logic [4:0]   rd;
    logic         reg_write;
    logic [N-1:0] pc_target;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_result;
    logic [4:0]   out_rd;
    logic         out_reg_write;
    logic         out_taken;
    logic [N-1:0] out_target;
    logic         out_illegal;

    modport master (
        output flush, in_valid, alu_result,
        output flag_v, flag_c, flag_n, flag_z,
        output is_branch, funct3, rd, reg_write,
        output pc_target, out_ready,
        input  in_ready, out_valid, out_result,
        input  out_rd, out_reg_write, out_taken,
        input  out_target, out_illegal
    );

    modport slave (
        input  flush, in_valid, alu_result,
        input  flag_v, flag_c, flag_n, flag_z,
        input  is_branch, funct3, rd, reg_write,
        input  pc_target, out_ready,
        output in_ready, out_valid, out_result,
        output out_rd, out_reg_write, out_taken,
        output out_target, out_illegal
    );

endinterface

// File: rtl/branch_cond.sv
// Combinational RISC-V branch condition from the flags of A-B.
// C=1 means A>=B unsigned; reserved funct3 010/011 flag illegal.
module branch_cond
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       is_branch,
    input  logic       flag_v,
    input  logic       flag_c,
    input  logic       flag_n,
    input  logic       flag_z,
    output logic       taken,
    output logic       illegal
);

    logic lt;

    assign lt = flag_n ^ flag_v;

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        if (is_branch) begin
            unique case (funct3)
                F3_BEQ:  taken = flag_z;
                F3_BNE:  taken = ~flag_z;
                F3_BLT:  taken = lt;
                F3_BGE:  taken = ~lt;
                F3_BLTU: taken = ~flag_c;
                F3_BGEU: taken = flag_c;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_stage.sv
// Branch resolve stage: evaluates the branch condition and holds results in a
// two-entry skid buffer. Optional BRANCH_RESOLVE_STATS_EN adds branch counters.
module branch_resolve_stage
    import riscv_pkg::*;
#(
    parameter int N = XLEN
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_resolve_stage_if.slave bus
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0]           branch_count,
    output logic [31:0]           taken_count
`endif
);

    typedef struct packed {
        logic [N-1:0] result;
        logic [4:0]   rd;
        logic         reg_write;
        logic         taken;
        logic         illegal;
        logic [N-1:0] target;
`ifdef BRANCH_RESOLVE_STATS_EN
        logic         is_branch;
`endif
    } entry_t;

    buf_state_e state_q;
    buf_state_e state_d;
    entry_t     head_q;
    entry_t     tail_q;
    entry_t     new_e;
    logic       in_hs;
    logic       out_hs;
    logic       load_head;
    logic       load_tail;
    logic       shift;
    logic       cond_taken;
    logic       cond_illegal;

    branch_cond u_cond (
        .funct3    (bus.funct3),
        .is_branch (bus.is_branch),
        .flag_v    (bus.flag_v),
        .flag_c    (bus.flag_c),
        .flag_n    (bus.flag_n),
        .flag_z    (bus.flag_z),
        .taken     (cond_taken),
        .illegal   (cond_illegal)
    );

    always_comb begin
        new_e           = '0;
        new_e.result    = bus.alu_result;
        new_e.rd        = bus.rd;
        new_e.reg_write = bus.reg_write;
        new_e.taken     = cond_taken;
        new_e.illegal   = cond_illegal;
        new_e.target    = bus.pc_target;
`ifdef BRANCH_RESOLVE_STATS_EN
        new_e.is_branch = bus.is_branch;
`endif
    end

    // in_ready depends only on registered state, never on out_ready
    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign in_hs         = bus.in_valid & bus.in_ready;
    assign out_hs        = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_head = 1'b0;
        load_tail = 1'b0;
        shift     = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_hs) begin
                    state_d   = ONE;
                    load_head = 1'b1;
                end
            end
            ONE: begin
                if (in_hs && out_hs) begin
                    load_head = 1'b1;
                end else if (in_hs) begin
                    state_d   = FULL;
                    load_tail = 1'b1;
                end else if (out_hs) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_hs) begin
                    state_d = ONE;
                    shift   = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // flush wins over any same-cycle handshake
        if (bus.flush) begin
            state_d   = EMPTY;
            load_head = 1'b0;
            load_tail = 1'b0;
            shift     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (load_head) begin
                head_q <= new_e;
            end else if (shift) begin
                head_q <= tail_q;
            end
            if (load_tail) begin
                tail_q <= new_e;
            end
        end
    end

    assign bus.out_result    = head_q.result;
    assign bus.out_rd        = head_q.rd;
    assign bus.out_reg_write = head_q.reg_write;
    assign bus.out_taken     = head_q.taken;
    assign bus.out_target    = head_q.target;
    assign bus.out_illegal   = head_q.illegal;

`ifdef BRANCH_RESOLVE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (out_hs && !bus.flush && head_q.is_branch) begin
            branch_count <= branch_count + 32'd1;
            if (head_q.taken) begin
                taken_count <= taken_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/branch_resolve_stage.md
# branch_resolve_stage

Pipeline stage directly downstream of the flag-producing ALU. Each cycle it accepts the ALU result and V/C/N/Z flags with the instruction's writeback and branch fields. It evaluates the RISC-V branch condition from the flags and presents a registered result, rd, writeback enable, taken decision and target to the writeback/fetch logic. A two-entry skid buffer with valid/ready handshaking on both sides decouples the ALU from downstream stalls.

## Interface
- N, default 32: datapath width (result, target).
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry
- alu_result  in  N  ALU Result
- flag_v, flag_c, flag_n, flag_z  in  1 each  ALU flags for the same operation
- is_branch  in  1  entry is a conditional branch
- funct3  in  3  branch condition encoding
- rd  in  5  destination register
- reg_write  in  1  writeback enable
- pc_target  in  N  branch target address
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_result  out  N  registered ALU result
- out_rd  out  5  registered rd
- out_reg_write  out  1  registered writeback enable
- out_taken  out  1  branch taken (0 for non-branch)
- out_target  out  N  registered pc_target
- out_illegal  out  1  is_branch with funct3 010/011

## Operation
- Condition, evaluated on input (ALU computed A−B, so C=1 ⇔ A≥B unsigned):
  - 000 BEQ: Z
  - 001 BNE: ~Z
  - 100 BLT: N^V
  - 101 BGE: ~(N^V)
  - 110 BLTU: ~C
  - 111 BGEU: C
  - 010/011: taken=0, illegal=1
- is_branch=0 forces taken=0 and illegal=0.
- Buffer FSM states: EMPTY, ONE, FULL (two entries). An input handshake is in_valid&in_ready; an output handshake is out_valid&out_ready.
  - EMPTY: on input handshake, go to ONE.
  - ONE:
    - input handshake only: go to FULL.
    - output handshake only: go to EMPTY.
    - both: stay in ONE; the new entry replaces the head.
  - FULL: on output handshake, the second entry becomes the head and the state goes to ONE. No input is accepted.
- Entries leave strictly in arrival order.
- in_ready = (state != FULL), driven from registered state only. There is no combinational path from out_ready to in_ready.
- out_valid = (state != EMPTY). All out_* fields come from the head register.
- Output fields stay stable while out_valid=1 and out_ready=0.
- flush=1 sets state to EMPTY at the next edge and discards all entries. flush takes priority over a same-cycle input handshake, which is dropped.

## Timing
- Reset values: out_valid=0, in_ready=1, out_result=0, out_rd=0, out_reg_write=0, out_taken=0, out_target=0, out_illegal=0, state=EMPTY.
- Latency is one cycle: an entry accepted at edge k is visible with out_valid=1 after edge k.
- Throughput is one entry per cycle while out_ready=1.
- A stall of out_ready=0 fills the buffer in at most two accepts. in_ready drops the cycle after the second accept.
- Asserting reset mid-operation clears everything immediately. No entry survives reset.

## Configuration
- BRANCH_RESOLVE_STATS_EN
  - Defined: adds outputs branch_count (32) and taken_count (32), both reset to 0.
    - branch_count increments on each output handshake with is_branch=1.
    - taken_count increments when that entry also has taken=1.
    - Both wrap from 0xFFFFFFFF to 0.
    - Neither counter changes on flush.
  - Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared package riscv_pkg holds:
  - branch funct3 constants (F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU)
  - buffer state typedef (EMPTY/ONE/FULL)
  - default width XLEN=32
- Sub-module branch_cond is combinational. Inputs are funct3, is_branch and V/C/N/Z; outputs are taken and illegal. It is instantiated once on the input side.

## Test plan
- Reset then idle → in_ready=1, out_valid=0, all outputs 0.
- BEQ with Z=1, then BLTU with C=0, then BGE with N=1, V=1, out_ready=1 → out_taken = 1, 1, 1 on consecutive cycles, each one cycle after its accept.
- out_ready=0 while three entries are offered (result 0x11, 0x22, 0x33) → 0x11 and 0x22 accepted, in_ready=0 during the third. Raising out_ready drains 0x11 then 0x22, then accepts 0x33.
- funct3=010 with is_branch=1 → out_taken=0, out_illegal=1. The same funct3 with is_branch=0 → out_illegal=0.
- FULL state plus flush and in_valid in the same cycle → next cycle out_valid=0, in_ready=1. The offered entry never appears at the output.
- With BRANCH_RESOLVE_STATS_EN: counter preloaded to 0xFFFFFFFF, then one taken branch drained → branch_count=0 and taken_count=0 (wrap). A non-branch entry leaves both unchanged.
